mips_dmem_mmio: RTL and testbench

Data-side responder for the single-cycle `mips` core. It services the core's `memwrite`/`aluout`/`writedata` request each cycle and returns `readdata` in the same cycle. Behind that interface it provides:
- a word-addressed data RAM;
- a free-running memory-mapped timer with a compare flag;
- a byte-wide transmit FIFO drained by an external sink over a valid/ready handshake.

It sits beside the instruction memory at the top level, in the same position as the plain data memory it replaces.

---
 rtl/mips_dmem_mmio.sv | 102 ++++++++++
 tb/tb_mips_dmem_mmio.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mips_dmem_mmio.sv
// Data-side responder for the single-cycle mips core: word RAM, free-running
// timer with sticky compare flag, and a byte TX FIFO drained over valid/ready.
module mips_dmem_mmio #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] A_TCOUNT = 32'hFFFF_0000;
  localparam logic [31:0] A_TCMP   = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_000C;
  localparam logic [PW:0] OCC_FULL = (PW + 1)'(FIFO_DEPTH);

  logic [31:0]   ram_q [RAM_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [31:0]   tcount_q, tcount_d, tcmp_q, tcmp_d;
  logic          match_q, match_d, ovf_q, ovf_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic          in_ram, full, empty, pop, push_req, push, wr_status;
  logic [AW-1:0] ram_idx;

  always_comb begin
    in_ram    = (addr[31:28] == 4'h0);
    ram_idx   = addr[AW+1:2];
    full      = (count_q == OCC_FULL);
    empty     = (count_q == '0);
    pop       = tx_valid && tx_ready;
    push_req  = memwrite && (addr == A_TXDATA);
    // A pop in the same cycle frees the slot the push needs.
    push      = push_req && (!full || pop);
    wr_status = memwrite && (addr == A_STATUS);

    tcount_d = (memwrite && addr == A_TCOUNT) ? writedata : tcount_q + 32'd1;
    tcmp_d   = (memwrite && addr == A_TCMP) ? writedata : tcmp_q;
    match_d  = (tcount_q == tcmp_q) || (match_q && !(wr_status && writedata[2]));
    ovf_d    = (push_req && full && !pop) || (ovf_q && !(wr_status && writedata[3]));

    head_d = pop  ? head_q + PW'(1) : head_q;
    tail_d = push ? tail_q + PW'(1) : tail_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    readdata = '0;
    if (in_ram) begin
      readdata = ram_q[ram_idx];
    end else begin
      case (addr)
        A_TCOUNT: readdata = tcount_q;
        A_TCMP:   readdata = tcmp_q;
        A_STATUS: readdata = {28'b0, ovf_q, match_q, empty, full};
        A_TXDATA: readdata = 32'(count_q);
        default:  readdata = '0;
      endcase
    end
  end

  assign tx_valid = !empty;
  assign tx_data  = fifo_q[head_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      tcount_q <= '0;
      tcmp_q   <= '1;
      match_q  <= 1'b0;
      ovf_q    <= 1'b0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else begin
      tcount_q <= tcount_d;
      tcmp_q   <= tcmp_d;
      match_q  <= match_d;
      ovf_q    <= ovf_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

  // Storage arrays carry no reset; only the pointers define their contents.
  always_ff @(posedge clk) begin
    if (!reset && memwrite && in_ram) ram_q[ram_idx] <= writedata;
    if (!reset && push) fifo_q[tail_q] <= writedata[7:0];
  end
endmodule

// File: tb/tb_mips_dmem_mmio.sv
// Self-checking bench for mips_dmem_mmio: direct register/RAM checks plus a
// scoreboard of expected TX bytes compared on every handshake.
module tb_mips_dmem_mmio;
  localparam logic [31:0] A_TCOUNT = 32'hFFFF_0000;
  localparam logic [31:0] A_TCMP   = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb [$];

  mips_dmem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr),
    .writedata(writedata), .readdata(readdata), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; addr = a; writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  // Inputs change only just after posedge, so a negedge sample sees the
  // handshake that the next edge will commit.
  always @(negedge clk) begin
    if (!reset && tx_valid && tx_ready) begin
      if (sb.size() == 0) chk("tx_unexpected_pop", 32'd1, 32'd0);
      else chk("tx_byte", {24'b0, tx_data}, {24'b0, sb.pop_front()});
    end
  end

  task automatic drain(input string tag, input int exp_cycles);
    int n;
    n = 0;
    tx_ready = 1'b1;
    while (tx_valid && n < 20) begin
      tick();
      n++;
    end
    tx_ready = 1'b0;
    chk({tag, "_cycles"}, n, exp_cycles);
    chk({tag, "_sb_left"}, sb.size(), 0);
    chk({tag, "_valid_low"}, {31'b0, tx_valid}, 0);
  endtask

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    rd_chk("rst_status", A_STATUS, 32'h2);
    rd_chk("rst_tcmp", A_TCMP, 32'hFFFF_FFFF);
    rd_chk("rst_tcount", A_TCOUNT, 32'h0);
    chk("rst_valid", {31'b0, tx_valid}, 0);

    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("ram_alias", 32'h0000_0110, 32'hDEAD_BEEF);
    wr(32'h0000_0014, 32'h1234_5678);
    rd_chk("ram_rd2", 32'h0000_0014, 32'h1234_5678);
    rd_chk("ram_keep", 32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("unmapped", 32'hFFFF_0010, 32'h0);

    wr(A_TCOUNT, 32'hFFFF_FFFE);
    rd_chk("tc_load", A_TCOUNT, 32'hFFFF_FFFE);
    tick();
    rd_chk("tc_inc", A_TCOUNT, 32'hFFFF_FFFF);
    tick();
    rd_chk("tc_wrap", A_TCOUNT, 32'h0);
    rd_chk("match_at_ffff", A_STATUS, 32'h6);
    wr(A_STATUS, 32'h4);
    rd_chk("match_clr0", A_STATUS, 32'h2);

    wr(A_TCMP, 32'd5);
    wr(A_TCOUNT, 32'd0);
    repeat (5) tick();
    rd_chk("tc_at5", A_TCOUNT, 32'd5);
    rd_chk("match_not_yet", A_STATUS, 32'h2);
    tick();
    rd_chk("match_set", A_STATUS, 32'h6);
    wr(A_STATUS, 32'h4);
    rd_chk("match_clr", A_STATUS, 32'h2);

    for (int i = 0; i < 9; i++) begin
      wr(A_TXDATA, 32'h41 + i);
      if (i < 8) sb.push_back(8'(8'h41 + i));
      if (i == 0) chk("valid_after_push", {31'b0, tx_valid}, 1);
    end
    rd_chk("fifo_ovf_status", A_STATUS, 32'h9);
    rd_chk("fifo_occ8", A_TXDATA, 32'd8);
    chk("head_stable", {24'b0, tx_data}, 32'h41);
    drain("drain1", 8);
    rd_chk("empty_status", A_STATUS, 32'hA);
    wr(A_STATUS, 32'h8);
    rd_chk("ovf_clr", A_STATUS, 32'h2);

    for (int i = 0; i < 8; i++) begin
      wr(A_TXDATA, 32'h61 + i);
      sb.push_back(8'(8'h61 + i));
    end
    rd_chk("full_status", A_STATUS, 32'h1);
    tx_ready = 1'b1;
    sb.push_back(8'h5A);
    wr(A_TXDATA, 32'h5A);
    tx_ready = 1'b0;
    rd_chk("pushpop_occ", A_TXDATA, 32'd8);
    rd_chk("pushpop_status", A_STATUS, 32'h1);
    drain("drain2", 8);

    for (int i = 0; i < 5; i++) begin
      wr(A_TXDATA, 32'h71 + i);
      sb.push_back(8'(8'h71 + i));
    end
    tx_ready = 1'b1;
    repeat (2) tick();
    rd_chk("mid_occ3", A_TXDATA, 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tx_ready = 1'b0;
    sb.delete();
    chk("rst_mid_valid", {31'b0, tx_valid}, 0);
    rd_chk("rst_mid_tcount", A_TCOUNT, 32'h0);
    rd_chk("rst_mid_status", A_STATUS, 32'h2);
    rd_chk("rst_mid_tcmp", A_TCMP, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
